hamming_secded_decoder: RTL and testbench
=========================================

// Module: hamming_secded_decoder
// PURPOSE
//  Parametrised extended-Hamming (SECDED) decoder: corrects any single-bit error, flags double-bit errors.
//  Two-stage pipeline with valid/ready handshakes on both sides, so it sits directly in a streaming datapath.
//  Keeps saturating counters of corrected and uncorrectable words for link-health monitoring.
// PARAMETERS
//  DATA_W  4   payload bits per word (2..57)
//  P       -   localparam: smallest p with 2**p >= DATA_W+p+1 (DATA_W=4 -> P=3)
//  N       -   localparam: DATA_W+P, highest Hamming position
//  CW_W    -   localparam: N+1, full codeword width including the overall-parity bit
//  CNT_W   16  error counter width
// PORTS
//  clk_dec       in   1       clock, all state changes on its rising edge
//  rst_dec       in   1       asynchronous reset, active-low
//  in_valid      in   1       in_cw carries a codeword
//  in_ready      out  1       decoder accepts this cycle
//  in_cw         in   CW_W    received codeword; [0]=overall parity, [i]=Hamming position i
//  corr_en       in   1       1: correct single errors; 0: detect only, data passed raw
//  out_valid     out  1       output word present
//  out_ready     in   1       downstream accepts
//  out_data      out  DATA_W  decoded payload
//  out_cw        out  CW_W    codeword after correction
//  out_status    out  2       00 clean, 01 single (corrected/correctable), 10 uncorrectable
//  out_syndrome  out  P       raw syndrome of the word
//  cnt_clr       in   1       synchronous clear of both counters
//  cnt_single    out  CNT_W   number of accepted words with status 01, saturating
//  cnt_double    out  CNT_W   number of accepted words with status 10, saturating
// BEHAVIOUR
//  - Layout: positions that are powers of two hold parity. Data fills the other positions 1..N in
//    ascending order, so out_data[0] is at position 3. in_cw[0] makes the XOR of all CW_W bits even.
//  - Stage 1 registers in_cw, corr_en, syndrome s (XOR of indices i with in_cw[i]=1) and
//    ovr (XOR of all CW_W bits).
//  - Stage 2 classifies, corrects and registers the outputs.
//  - Decode rules:
//      s==0, ovr==0         -> status 00, word unchanged
//      s==0, ovr==1         -> status 01, flip bit 0 (payload unaffected)
//      s in 1..N, ovr==1    -> status 01, flip position s
//      s>N, ovr==1          -> status 10, no flip
//      s!=0, ovr==0         -> status 10, no flip
//  - corr_en=0: flips are suppressed; status, syndrome and counters are still reported.
//    corr_en is sampled with its own input beat.
//  - Handshake:
//      advance = !out_valid | out_ready; in_ready = advance (combinational from out_ready).
//      Input transfer when in_valid & in_ready. Output transfer when out_valid & out_ready.
//      Latency is 2 cycles from input transfer to out_valid when there is no backpressure;
//      throughput is 1 word/cycle.
//      With advance=0 all pipeline registers hold.
//      out_* stay stable while out_valid=1 & out_ready=0.
//      Bubbles propagate, so stage valid bits shift even when in_valid=0.
//  - Counters:
//      Increment by 1 on each output transfer with the matching status; saturate at 2**CNT_W-1.
//      cnt_clr has priority: a clear in the same cycle as an increment leaves the count at 0.
//  - Reset (rst_dec=0):
//      Immediately clears both stage valid bits, out_valid, out_data, out_cw, out_status,
//      out_syndrome, cnt_single and cnt_double to 0.
//      In-flight words are discarded.
//      in_ready=1 after reset, because out_valid=0.
// TESTING (DATA_W=4, CNT_W=16; clean codeword for data 4'hB is in_cw=8'hAA)
//  1. 8'hAA, out_ready=1 -> 2 cycles later out_data=4'hB, status 00, syndrome 0, cnt_single=0.
//  2. 8'h8A (pos 5 flipped), corr_en=1 -> out_data=4'hB, out_cw=8'hAA, status 01, syndrome 5,
//     cnt_single=1. Same word with corr_en=0 -> out_data=4'h9, status 01.
//  3. 8'h82 (pos 3 and 5 flipped) -> status 10, syndrome 6, out_cw=8'h82, cnt_double=1.
//     8'hAB (bit 0 flipped) -> status 01, syndrome 0, out_data=4'hB.
//  4. Back-to-back stream of 6 words, out_ready held 0 for 3 cycles mid-stream -> no loss or
//     duplication, order preserved, in_ready=0 while stalled, out_* stable during the stall.
//  5. Preload cnt_single to 16'hFFFE, send 3 single-error words -> count sticks at 16'hFFFF.
//     cnt_clr asserted together with an accepted single-error word -> 0.
//  6. Assert rst_dec low with 2 words in flight -> out_valid=0 and counters 0 at once;
//     after release, the next word decodes with 2-cycle latency.

Source files
------------

// File: rtl/hamming_secded_decoder.sv
// hamming_secded_decoder
// Two-stage extended-Hamming (SECDED) decoder with valid/ready handshakes on both sides.
// Stage 1 captures the received word with its syndrome and overall parity; stage 2 classifies,
// optionally corrects, and presents the result. Saturating counters track corrected and
// uncorrectable words for link-health monitoring.
module hamming_secded_decoder #(
   parameter int unsigned DATA_W = 4,
   parameter int unsigned CNT_W  = 16,
   // Smallest p with 2**p >= DATA_W+p+1, tabulated over the legal DATA_W range 2..57
   localparam int unsigned P    = (DATA_W <= 4)  ? 3 :
                                  (DATA_W <= 11) ? 4 :
                                  (DATA_W <= 26) ? 5 : 6,
   localparam int unsigned N    = DATA_W + P,
   localparam int unsigned CW_W = N + 1
) (
   input  logic              clk_dec,
   input  logic              rst_dec,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CW_W-1:0]   in_cw,
   input  logic              corr_en,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CW_W-1:0]   out_cw,
   output logic [1:0]        out_status,
   output logic [P-1:0]      out_syndrome,
   input  logic              cnt_clr,
   output logic [CNT_W-1:0]  cnt_single,
   output logic [CNT_W-1:0]  cnt_double
);

   localparam logic [1:0]       StClean  = 2'b00;
   localparam logic [1:0]       StSingle = 2'b01;
   localparam logic [1:0]       StDouble = 2'b10;
   localparam logic [CNT_W-1:0] CntMax   = '1;

   // Hamming position of payload bit idx: the idx-th position that is not a power of two
   function automatic int unsigned data_pos(int unsigned idx);
      int unsigned seen;
      data_pos = 0;
      seen     = 0;
      for (int unsigned pos = 1; pos < 128; pos++) begin
         if ((pos & (pos - 1)) != 0) begin
            if (seen == idx && data_pos == 0) data_pos = pos;
            seen++;
         end
      end
   endfunction

   logic              advance;
   logic              out_fire;

   logic              s1_valid_q;
   logic [CW_W-1:0]   s1_cw_q;
   logic              s1_corr_q;
   logic [P-1:0]      s1_syn_q;
   logic              s1_ovr_q;

   logic [P-1:0]      syn_in;
   logic [CW_W-1:0]   flip_mask;
   logic [CW_W-1:0]   fixed_cw;
   logic [DATA_W-1:0] fixed_data;
   logic [1:0]        status;

   logic              out_valid_q;
   logic [DATA_W-1:0] out_data_q;
   logic [CW_W-1:0]   out_cw_q;
   logic [1:0]        out_status_q;
   logic [P-1:0]      out_syndrome_q;
   logic [CNT_W-1:0]  cnt_single_q, cnt_single_d;
   logic [CNT_W-1:0]  cnt_double_q, cnt_double_d;

   // The whole pipeline moves together whenever the output slot is free or being drained
   assign advance  = !out_valid_q | out_ready;
   assign in_ready = advance;
   assign out_fire = out_valid_q & out_ready;

   // Syndrome: XOR of the indices of all set Hamming positions
   always_comb begin
      syn_in = '0;
      for (int unsigned i = 1; i < CW_W; i++) begin
         if (in_cw[i]) syn_in = syn_in ^ P'(i);
      end
   end

   // Stage 1: capture the word, its correction mode, syndrome and overall parity
   always_ff @(posedge clk_dec or negedge rst_dec) begin
      if (!rst_dec) begin
         s1_valid_q <= 1'b0;
         s1_cw_q    <= '0;
         s1_corr_q  <= 1'b0;
         s1_syn_q   <= '0;
         s1_ovr_q   <= 1'b0;
      end else if (advance) begin
         s1_valid_q <= in_valid;
         if (in_valid) begin
            s1_cw_q   <= in_cw;
            s1_corr_q <= corr_en;
            s1_syn_q  <= syn_in;
            s1_ovr_q  <= ^in_cw;
         end
      end
   end

   // Classify the stage-1 word, build the flip mask and extract the payload
   always_comb begin
      flip_mask  = '0;
      status     = StClean;
      fixed_data = '0;
      if (s1_syn_q == '0) begin
         // Only the overall parity bit is wrong; the payload is intact
         if (s1_ovr_q) begin
            status       = StSingle;
            flip_mask[0] = 1'b1;
         end
      end else if (s1_ovr_q && (32'(s1_syn_q) <= N)) begin
         status = StSingle;
         for (int unsigned i = 1; i < CW_W; i++) begin
            if (s1_syn_q == P'(i)) flip_mask[i] = 1'b1;
         end
      end else begin
         // Even overall parity with a non-zero syndrome, or a syndrome beyond the last position
         status = StDouble;
      end
      fixed_cw = s1_corr_q ? (s1_cw_q ^ flip_mask) : s1_cw_q;
      for (int unsigned k = 0; k < DATA_W; k++) begin
         fixed_data[k] = fixed_cw[data_pos(k)];
      end
   end

   // Stage 2: register the decoded result; held while the consumer stalls
   always_ff @(posedge clk_dec or negedge rst_dec) begin
      if (!rst_dec) begin
         out_valid_q    <= 1'b0;
         out_data_q     <= '0;
         out_cw_q       <= '0;
         out_status_q   <= StClean;
         out_syndrome_q <= '0;
      end else if (advance) begin
         out_valid_q <= s1_valid_q;
         if (s1_valid_q) begin
            out_data_q     <= fixed_data;
            out_cw_q       <= fixed_cw;
            out_status_q   <= status;
            out_syndrome_q <= s1_syn_q;
         end
      end
   end

   // Counter next state: clear wins over an increment in the same cycle
   always_comb begin
      cnt_single_d = cnt_single_q;
      cnt_double_d = cnt_double_q;
      if (cnt_clr) begin
         cnt_single_d = '0;
         cnt_double_d = '0;
      end else if (out_fire) begin
         if (out_status_q == StSingle && cnt_single_q != CntMax) begin
            cnt_single_d = cnt_single_q + 1'b1;
         end
         if (out_status_q == StDouble && cnt_double_q != CntMax) begin
            cnt_double_d = cnt_double_q + 1'b1;
         end
      end
   end

   // Error counter state
   always_ff @(posedge clk_dec or negedge rst_dec) begin
      if (!rst_dec) begin
         cnt_single_q <= '0;
         cnt_double_q <= '0;
      end else begin
         cnt_single_q <= cnt_single_d;
         cnt_double_q <= cnt_double_d;
      end
   end

   assign out_valid    = out_valid_q;
   assign out_data     = out_data_q;
   assign out_cw       = out_cw_q;
   assign out_status   = out_status_q;
   assign out_syndrome = out_syndrome_q;
   assign cnt_single   = cnt_single_q;
   assign cnt_double   = cnt_double_q;

endmodule

// File: tb/tb_hamming_secded_decoder.sv
// tb_hamming_secded_decoder
// Bench for the SECDED decoder at DATA_W=4. A second instance with 2-bit counters shares all
// inputs so counter saturation is reached quickly.
module tb_hamming_secded_decoder;

   typedef struct {
      logic [7:0] cw;
      logic       ce;
      logic [3:0] data;
      logic [7:0] ocw;
      logic [1:0] st;
      logic [2:0] syn;
   } vec_t;

   logic        clk_dec;
   logic        rst_dec;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  in_cw;
   logic        corr_en;
   logic        out_valid;
   logic        out_ready;
   logic [3:0]  out_data;
   logic [7:0]  out_cw;
   logic [1:0]  out_status;
   logic [2:0]  out_syndrome;
   logic        cnt_clr;
   logic [15:0] cnt_single;
   logic [15:0] cnt_double;

   logic        in_ready_s;
   logic        out_valid_s;
   logic [3:0]  out_data_s;
   logic [7:0]  out_cw_s;
   logic [1:0]  out_status_s;
   logic [2:0]  out_syndrome_s;
   logic [1:0]  cnt_single_s;
   logic [1:0]  cnt_double_s;

   int          n_pass = 0;
   int          n_total = 0;
   vec_t        sb[$];
   logic [15:0] exp_single = '0;
   logic [15:0] exp_double = '0;
   logic [1:0]  exp_single_s = '0;
   logic [1:0]  exp_double_s = '0;
   vec_t        tbl[12];

   hamming_secded_decoder #(.DATA_W(4), .CNT_W(16)) u_dut (
      .clk_dec      (clk_dec),
      .rst_dec      (rst_dec),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_cw        (in_cw),
      .corr_en      (corr_en),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_data     (out_data),
      .out_cw       (out_cw),
      .out_status   (out_status),
      .out_syndrome (out_syndrome),
      .cnt_clr      (cnt_clr),
      .cnt_single   (cnt_single),
      .cnt_double   (cnt_double)
   );

   hamming_secded_decoder #(.DATA_W(4), .CNT_W(2)) u_dut_sat (
      .clk_dec      (clk_dec),
      .rst_dec      (rst_dec),
      .in_valid     (in_valid),
      .in_ready     (in_ready_s),
      .in_cw        (in_cw),
      .corr_en      (corr_en),
      .out_valid    (out_valid_s),
      .out_ready    (out_ready),
      .out_data     (out_data_s),
      .out_cw       (out_cw_s),
      .out_status   (out_status_s),
      .out_syndrome (out_syndrome_s),
      .cnt_clr      (cnt_clr),
      .cnt_single   (cnt_single_s),
      .cnt_double   (cnt_double_s)
   );

   initial clk_dec = 1'b0;
   always #5 clk_dec = ~clk_dec;

   function automatic void chk(input string nm, input longint unsigned act,
                               input longint unsigned exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
   endfunction

   // Reference encoder: payload at the non-power-of-two positions, parity bit 2**j covers
   // every position with bit j set, bit 0 makes the whole word even
   function automatic logic [7:0] encode(input logic [3:0] d);
      logic [7:0] cw;
      int         dpos[4];
      logic       par;
      dpos = '{3, 5, 6, 7};
      cw = '0;
      for (int k = 0; k < 4; k++) cw[dpos[k]] = d[k];
      for (int j = 0; j < 3; j++) begin
         par = 1'b0;
         for (int p = 1; p < 8; p++) if (((p >> j) & 1) == 1) par = par ^ cw[p];
         cw[1 << j] = par;
      end
      cw[0] = ^cw[7:1];
      return cw;
   endfunction

   function automatic logic [3:0] extract(input logic [7:0] cw);
      int         dpos[4];
      logic [3:0] d;
      dpos = '{3, 5, 6, 7};
      for (int k = 0; k < 4; k++) d[k] = cw[dpos[k]];
      return d;
   endfunction

   // Expected result from knowledge of which bits were corrupted
   function automatic vec_t model(input logic [3:0] data, input int nflip, input int a,
                                  input int b, input logic ce);
      vec_t       e;
      logic [7:0] clean;
      logic [7:0] bad;
      clean = encode(data);
      bad   = clean;
      if (nflip >= 1) bad[a] = ~bad[a];
      if (nflip == 2) bad[b] = ~bad[b];
      e.cw = bad;
      e.ce = ce;
      if (nflip == 0) begin
         e.st  = 2'd0;
         e.syn = 3'd0;
      end else if (nflip == 1) begin
         e.st  = 2'd1;
         e.syn = 3'(a);
      end else begin
         e.st  = 2'd2;
         e.syn = 3'(a ^ b);
      end
      e.ocw  = (nflip == 1 && ce) ? clean : bad;
      e.data = (nflip == 0 || (nflip == 1 && ce)) ? data : extract(bad);
      return e;
   endfunction

   // Output monitor: every presented word must match the oldest pending expectation
   always @(negedge clk_dec) begin
      logic       fired;
      logic [1:0] st;
      #2;
      fired = 1'b0;
      st    = 2'd0;
      if (rst_dec) begin
         chk("cnt_single", cnt_single, exp_single);
         chk("cnt_double", cnt_double, exp_double);
         chk("cnt_single_sat", cnt_single_s, exp_single_s);
         chk("cnt_double_sat", cnt_double_s, exp_double_s);
         if (out_valid) begin
            if (sb.size() == 0) begin
               n_total++;
               $display("FAIL spurious_out: out_valid got 1 expected 0 (t=%0t)", $time);
            end else begin
               chk("out_data", out_data, sb[0].data);
               chk("out_cw", out_cw, sb[0].ocw);
               chk("out_status", out_status, sb[0].st);
               chk("out_syndrome", out_syndrome, sb[0].syn);
               if (out_ready) begin
                  st = sb[0].st;
                  void'(sb.pop_front());
                  fired = 1'b1;
               end
            end
         end
         if (cnt_clr) begin
            exp_single   = '0;
            exp_double   = '0;
            exp_single_s = '0;
            exp_double_s = '0;
         end else if (fired) begin
            if (st == 2'd1) begin
               if (exp_single != 16'hFFFF) exp_single++;
               if (exp_single_s != 2'd3) exp_single_s++;
            end
            if (st == 2'd2) begin
               if (exp_double != 16'hFFFF) exp_double++;
               if (exp_double_s != 2'd3) exp_double_s++;
            end
         end
      end
   end

   task automatic send(input vec_t e, input bit rnd_rdy);
      int tries;
      bit done;
      tries = 0;
      done  = 0;
      while (!done) begin
         @(negedge clk_dec);
         in_valid  = 1'b1;
         in_cw     = e.cw;
         corr_en   = e.ce;
         cnt_clr   = 1'b0;
         out_ready = rnd_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
         #3;
         if (in_ready) begin
            sb.push_back(e);
            done = 1;
         end else if (++tries > 50) begin
            n_total++;
            $display("FAIL send_timeout: in_ready got 0 expected 1 within 50 cycles");
            done = 1;
         end
      end
   endtask

   task automatic idle(input bit ordy, input bit clr);
      @(negedge clk_dec);
      in_valid  = 1'b0;
      out_ready = ordy;
      cnt_clr   = clr;
      #3;
   endtask

   task automatic drain(input bit clr);
      int cyc;
      cyc = 0;
      while (sb.size() != 0 && cyc < 100) begin
         idle(1'b1, clr);
         cyc++;
      end
      if (sb.size() != 0) begin
         n_total++;
         $display("FAIL drain_timeout: pending words got %0d expected 0", sb.size());
         sb.delete();
      end
   endtask

   // Accept a word on an idle pipeline and check it appears exactly two cycles later
   task automatic lat_check(input vec_t e);
      send(e, 1'b0);
      idle(1'b1, 1'b0);
      chk("lat_cycle1_out_valid", out_valid, 0);
      idle(1'b1, 1'b0);
      chk("lat_cycle2_out_valid", out_valid, 1);
   endtask

   initial begin
      vec_t e;
      int   nf;
      int   a;
      int   b;
      int   idx;

      //        cw     ce    data   ocw    st     syn
      tbl[0]  = '{8'hAA, 1'b1, 4'hB, 8'hAA, 2'd0, 3'd0};
      tbl[1]  = '{8'h8A, 1'b1, 4'hB, 8'hAA, 2'd1, 3'd5};
      tbl[2]  = '{8'h8A, 1'b0, 4'h9, 8'h8A, 2'd1, 3'd5};
      tbl[3]  = '{8'h82, 1'b1, 4'h8, 8'h82, 2'd2, 3'd6};
      tbl[4]  = '{8'hAB, 1'b1, 4'hB, 8'hAA, 2'd1, 3'd0};
      tbl[5]  = '{8'hAB, 1'b0, 4'hB, 8'hAB, 2'd1, 3'd0};
      tbl[6]  = '{8'h2A, 1'b1, 4'hB, 8'hAA, 2'd1, 3'd7};
      tbl[7]  = '{8'hA8, 1'b1, 4'hB, 8'hAA, 2'd1, 3'd1};
      tbl[8]  = '{8'h00, 1'b1, 4'h0, 8'h00, 2'd0, 3'd0};
      tbl[9]  = '{8'hFF, 1'b1, 4'hF, 8'hFF, 2'd0, 3'd0};
      tbl[10] = '{8'hAE, 1'b1, 4'hB, 8'hAA, 2'd1, 3'd2};
      tbl[11] = '{8'hA0, 1'b1, 4'hA, 8'hA0, 2'd2, 3'd2};

      rst_dec   = 1'b1;
      in_valid  = 1'b0;
      in_cw     = '0;
      corr_en   = 1'b1;
      out_ready = 1'b0;
      cnt_clr   = 1'b0;
      #1 rst_dec = 1'b0;
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_data", out_data, 0);
      chk("rst_cnt_single", cnt_single, 0);
      chk("rst_cnt_double", cnt_double, 0);
      @(negedge clk_dec);
      @(negedge clk_dec);
      rst_dec = 1'b1;

      // Directed vectors, first one also checks latency
      lat_check(tbl[0]);
      drain(1'b0);
      for (int i = 1; i < 12; i++) send(tbl[i], 1'b0);
      drain(1'b0);

      // Six back-to-back words with a three-cycle consumer stall
      idx = 0;
      for (int c = 0; c < 40 && (idx < 6 || sb.size() != 0); c++) begin
         @(negedge clk_dec);
         out_ready = !(c >= 3 && c < 6);
         cnt_clr   = 1'b0;
         in_valid  = (idx < 6);
         e         = model(4'(idx + 3), idx % 3, idx + 1, 0, 1'b1);
         in_cw     = e.cw;
         corr_en   = e.ce;
         #3;
         if (c >= 3 && c < 6) chk("stall_in_ready", in_ready, 0);
         if (in_valid && in_ready) begin
            sb.push_back(e);
            idx++;
         end
      end
      drain(1'b0);

      // Randomized traffic with random gaps, backpressure and occasional counter clears
      for (int i = 0; i < 300; i++) begin
         nf = $urandom_range(0, 2);
         a  = $urandom_range(0, 7);
         b  = (a + $urandom_range(1, 7)) % 8;
         e  = model(4'($urandom_range(0, 15)), nf, a, b, ($urandom_range(0, 3) != 0));
         send(e, 1'b1);
         if ($urandom_range(0, 3) == 0) idle($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0);
      end
      drain(1'b0);

      // Asynchronous reset with two words in flight
      @(negedge clk_dec);
      in_valid  = 1'b1;
      in_cw     = 8'h8A;
      corr_en   = 1'b1;
      out_ready = 1'b1;
      #3 if (in_ready) sb.push_back(tbl[1]);
      @(negedge clk_dec);
      in_cw = 8'h82;
      #3 if (in_ready) sb.push_back(tbl[3]);
      @(negedge clk_dec);
      in_valid  = 1'b0;
      out_ready = 1'b0;
      #3;
      rst_dec = 1'b0;
      #1;
      chk("async_rst_out_valid", out_valid, 0);
      chk("async_rst_out_status", out_status, 0);
      chk("async_rst_out_cw", out_cw, 0);
      chk("async_rst_cnt_single", cnt_single, 0);
      chk("async_rst_cnt_double", cnt_double, 0);
      sb.delete();
      exp_single   = '0;
      exp_double   = '0;
      exp_single_s = '0;
      exp_double_s = '0;
      @(negedge clk_dec);
      @(negedge clk_dec);
      rst_dec = 1'b1;
      #1;
      chk("post_rst_in_ready", in_ready, 1);
      chk("post_rst_out_valid", out_valid, 0);
      lat_check(tbl[0]);
      drain(1'b0);

      // Saturation on the 2-bit instance, then clear colliding with an increment
      for (int i = 0; i < 5; i++) send(tbl[1], 1'b0);
      drain(1'b0);
      idle(1'b1, 1'b0);
      chk("sat_cnt_single_2bit", cnt_single_s, 3);
      chk("sat_cnt_single_16bit", cnt_single, 5);
      send(tbl[1], 1'b0);
      drain(1'b1);
      idle(1'b1, 1'b0);
      chk("clr_prio_cnt_single", cnt_single, 0);
      chk("clr_prio_cnt_single_2bit", cnt_single_s, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
